key_edge_capture_pio: RTL and testbench

Avalon-MM slave input port for the board pushbuttons: the input-direction counterpart of the HEX display output ports on the same system interconnect. Synchronizes and debounces `WIDTH` raw button lines, exposes the clean level, latches press events in a write-one-to-clear edge-capture register, and raises a level interrupt for unmasked captured events. Software reads it through the same 2-bit, 32-bit-data, zero-wait-state slave protocol as the output ports.

---
 rtl/key_edge_capture_pio_if.sv | 11 +
 rtl/key_edge_capture_pio.sv | 110 +++++++++++
 tb/tb_key_edge_capture_pio.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/key_edge_capture_pio_if.sv
// Avalon-MM slave bus for the pushbutton PIO: 2-bit address, 32-bit data, zero wait states.
interface key_edge_capture_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/key_edge_capture_pio.sv
// Pushbutton input port: synchronize and debounce each button line, expose the pressed
// state, capture press events in a write-one-to-clear register and raise a masked level irq.
module key_edge_capture_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    key_edge_capture_pio_if.slave    avs,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] level_c;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] press_c;
    logic [WIDTH-1:0] clear_c;
    logic             wr_en_c;

    // Synchronizer chain resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= IDLE_LVL;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign level_c = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after it differs from the stable one for the full count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (level_c[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = level_c[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign wr_en_c = avs.chipselect && !avs.write_n;
    assign press_c = stable_q & ~stable_dly_q;
    assign clear_c = (wr_en_c && avs.address == ADDR_EDGECAP) ? avs.writedata[WIDTH-1:0] : '0;

    // A press detected on the same edge as a clear keeps its capture bit set.
    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en_c && avs.address == ADDR_IRQMASK) irqmask_d = avs.writedata[WIDTH-1:0];
        edgecap_d = press_c | (edgecap_q & ~clear_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Zero-wait-state read mux; reserved address and unused upper bits read zero.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA:    avs.readdata = 32'(stable_q);
            ADDR_IRQMASK: avs.readdata = 32'(irqmask_q);
            ADDR_EDGECAP: avs.readdata = 32'(edgecap_q);
            default:      avs.readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

    generate
        if (WIDTH < 32) begin : g_wdata_upper
            logic unused_wdata_upper;
            assign unused_wdata_upper = ^avs.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_key_edge_capture_pio.sv
// Bench for key_edge_capture_pio: scoreboarded register reads and irq checks across
// reset, glitch rejection, press/clear, clear/set collision and multi-bit captures.
module tb_key_edge_capture_pio;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    key_edge_capture_pio_if bus ();

    key_edge_capture_pio #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs(bus.slave), .in_port(in_port), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against what the DUT shows now.
    task automatic pop_cmp(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, got, e.exp);
        end
    endtask

    task automatic exp_rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        sb.push_back('{tag, exp});
        bus.address = addr;
        #1;
        pop_cmp(bus.readdata);
    endtask

    task automatic exp_irq(input logic exp, input string tag);
        sb.push_back('{tag, 32'(exp)});
        #1;
        pop_cmp(32'(irq));
    endtask

    // Called at a negedge; the write is sampled at the next posedge, returns at the following negedge.
    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        in_port        = 4'b1111;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        cycles(3);
        reset_n = 1'b1;
        cycles(2);

        // Reset mid-press discards everything.
        in_port = 4'b0000;
        cycles(SYNC + DEB + 2);
        wr(2'd2, 32'hF);
        cycles(1);
        #2 reset_n = 1'b0;
        in_port = 4'b1111;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        for (int a = 0; a < 4; a++) exp_rd(2'(a), 32'h0, $sformatf("reset_rd%0d", a));
        exp_irq(1'b0, "reset_irq");
        cycles(SYNC + DEB + 3);
        exp_rd(2'd0, 32'h0, "reset_idle_data");

        // Glitch shorter than the debounce window is rejected.
        in_port = 4'b1110;
        cycles(3);
        in_port = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_rd(2'd0, 32'h0, "glitch_data");
            exp_rd(2'd3, 32'h0, "glitch_edgecap");
            exp_irq(1'b0, "glitch_irq");
        end

        // Clean press on bit 0 with irq masked off.
        in_port = 4'b1110;
        cycles(SYNC + DEB - 1);
        exp_rd(2'd0, 32'h0, "press_data_early");
        cycles(1);
        exp_rd(2'd0, 32'h1, "press_data");
        exp_rd(2'd3, 32'h0, "press_edgecap_early");
        cycles(1);
        exp_rd(2'd3, 32'h1, "press_edgecap");
        exp_irq(1'b0, "press_irq_masked");
        wr(2'd2, 32'h1);
        exp_irq(1'b1, "mask_irq");
        exp_rd(2'd2, 32'h1, "mask_rd");

        // Writing zero leaves captures alone; writing one clears.
        wr(2'd3, 32'h0);
        exp_rd(2'd3, 32'h1, "clr0_edgecap");
        wr(2'd3, 32'h1);
        exp_rd(2'd3, 32'h0, "clr1_edgecap");
        exp_irq(1'b0, "clr1_irq");
        in_port = 4'b1111;
        cycles(SYNC + DEB + 3);
        exp_rd(2'd0, 32'h0, "release_data");
        exp_rd(2'd3, 32'h0, "release_edgecap");

        // Clear lands on the same edge that captures a new press.
        in_port = 4'b1110;
        cycles(SYNC + DEB);
        wr(2'd3, 32'h1);
        exp_rd(2'd3, 32'h1, "collide_edgecap");
        exp_irq(1'b1, "collide_irq");
        wr(2'd3, 32'h1);
        exp_rd(2'd3, 32'h0, "collide_clear");
        in_port = 4'b1111;
        cycles(SYNC + DEB + 3);

        // Staggered presses on bits 1 and 3, only bit 3 unmasked.
        wr(2'd2, 32'h8);
        in_port = 4'b1101;
        cycles(2);
        in_port = 4'b0101;
        exp_rd(2'd1, 32'h0, "multi_rsv_a");
        cycles(SYNC + DEB + 4);
        exp_rd(2'd0, 32'hA, "multi_data");
        exp_rd(2'd3, 32'hA, "multi_edgecap");
        exp_irq(1'b1, "multi_irq");
        wr(2'd1, 32'hFFFF_FFFF);
        exp_rd(2'd1, 32'h0, "multi_rsv_b");
        wr(2'd3, 32'h8);
        exp_irq(1'b0, "multi_clr_irq");
        exp_rd(2'd3, 32'h2, "multi_clr_edgecap");
        exp_rd(2'd1, 32'h0, "multi_rsv_c");
        in_port = 4'b1111;
        cycles(SYNC + DEB + 3);
        exp_rd(2'd0, 32'h0, "multi_release");
        exp_rd(2'd3, 32'h2, "multi_release_edgecap");

        if (sb.size() != 0) check_eq("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
